coalescing_store_buffer: RTL and testbench

- Parametrised store buffer between the core's memory stage and the data cache.
- Holds up to DEPTH committed stores (address, data, byte mask) in FIFO order and merges same-word stores into one entry.
- Answers load lookups with byte-accurate forwarding, reporting full, partial or no hit.
- Drains its oldest entry to the cache over a valid/ready handshake.

---
 rtl/sb_pkg.sv | 24 ++
 rtl/sb_match.sv | 22 ++
 rtl/coalescing_store_buffer.sv | 156 +++++++++++++++
 tb/tb_coalescing_store_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared entry type, widths and byte-mask helper for the coalescing store buffer
package sb_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;
    localparam int SB_BE_W   = SB_DATA_W / 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [SB_BE_W-1:0]   be;
    } sb_entry_t;

    function automatic logic [SB_DATA_W-1:0] be_to_mask(input logic [SB_BE_W-1:0] be);
        logic [SB_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < SB_BE_W; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - DEPTH-way word-address comparator with one-hot hit vector
module sb_match #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    input  logic [ADDR_W-1:0]            key,
    output logic [DEPTH-1:0]             hit,
    output logic                         hit_any
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = entry_valid[i] && (entry_addr[i] == key);
        end
    end

    assign hit_any = |hit;

endmodule

// File: rtl/coalescing_store_buffer.sv
// rtl/coalescing_store_buffer.sv - FIFO store buffer with same-word coalescing, load forwarding and cache drain
// Address/data widths must equal the sb_pkg entry widths; DEPTH is free (power of 2, >= 2).
module coalescing_store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    input  logic [BE_W-1:0]          st_be,
    input  logic                     ld_valid,
    input  logic [ADDR_W-1:0]        ld_addr,
    input  logic [BE_W-1:0]          ld_be,
    output logic                     ld_resp_valid,
    output logic                     ld_hit,
    output logic                     ld_partial,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     drain_valid,
    input  logic                     drain_ready,
    output logic [ADDR_W-1:0]        drain_addr,
    output logic [DATA_W-1:0]        drain_data,
    output logic [BE_W-1:0]          drain_be,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t                   entries [DEPTH];
    logic [PTR_W-1:0]            head;
    logic [PTR_W-1:0]            tail;

    logic [DEPTH-1:0]            ent_valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [DEPTH-1:0]            st_hit;
    logic [DEPTH-1:0]            ld_hit_vec;
    logic                        st_any;
    logic                        ld_any;
    logic [PTR_W-1:0]            st_idx;
    logic [PTR_W-1:0]            ld_idx;

    logic                        drain_pop;
    logic                        usable_match;
    logic                        st_fire;
    logic                        coalesce;
    logic                        allocate;
    logic [DATA_W-1:0]           st_mask;
    logic [DATA_W-1:0]           merged_data;
    logic                        ld_lookup;
    logic                        ld_covered;

    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_addr[i]  = entries[i].addr;
        end
    end

    sb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_st_match (
        .entry_valid (ent_valid),
        .entry_addr  (ent_addr),
        .key         (st_addr),
        .hit         (st_hit),
        .hit_any     (st_any)
    );

    sb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ld_match (
        .entry_valid (ent_valid),
        .entry_addr  (ent_addr),
        .key         (ld_addr),
        .hit         (ld_hit_vec),
        .hit_any     (ld_any)
    );

    // Coalescing keeps each address in at most one entry, so OR-ing indices is a clean one-hot decode.
    always_comb begin
        st_idx = '0;
        ld_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_hit[i]) st_idx = st_idx | PTR_W'(i);
            if (ld_hit_vec[i]) ld_idx = ld_idx | PTR_W'(i);
        end
    end

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign drain_valid = !empty && !flush;
    assign drain_pop   = drain_valid && drain_ready;
    assign drain_addr  = entries[head].addr;
    assign drain_data  = entries[head].data;
    assign drain_be    = entries[head].be;

    // A match on the head that leaves this cycle cannot absorb the store; it must allocate behind it.
    assign usable_match = st_any && !(st_hit[head] && drain_pop);
    assign st_ready     = !flush && (!full || usable_match);
    assign st_fire      = st_valid && st_ready;
    assign coalesce     = st_fire && usable_match;
    assign allocate     = st_fire && !usable_match;

    assign st_mask     = be_to_mask(st_be);
    assign merged_data = (entries[st_idx].data & ~st_mask) | (st_data & st_mask);

    assign ld_lookup  = ld_valid && !flush && ld_any;
    assign ld_covered = ((entries[ld_idx].be & ld_be) == ld_be);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ld_resp_valid <= 1'b0;
            ld_hit        <= 1'b0;
            ld_partial    <= 1'b0;
            ld_data       <= '0;
        end else begin
            ld_resp_valid <= ld_valid;
            ld_hit        <= ld_lookup && ld_covered;
            ld_partial    <= ld_lookup && !ld_covered;
            ld_data       <= ld_lookup ? (entries[ld_idx].data & be_to_mask(entries[ld_idx].be)) : '0;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (drain_pop) begin
                    entries[head] <= '0;
                    head          <= head + PTR_W'(1);
                end
                if (coalesce) begin
                    entries[st_idx].data <= merged_data;
                    entries[st_idx].be   <= entries[st_idx].be | st_be;
                end
                if (allocate) begin
                    entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data & st_mask, be: st_be};
                    tail          <= tail + PTR_W'(1);
                end
                count <= count + CNT_W'(allocate) - CNT_W'(drain_pop);
            end
        end
    end

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// tb/tb_coalescing_store_buffer.sv - directed vector table plus randomized queue-model checking
module tb_coalescing_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, flush, st_valid, st_ready, ld_valid;
    logic [31:0] st_addr, st_data, ld_addr;
    logic [3:0]  st_be, ld_be;
    logic        ld_resp_valid, ld_hit, ld_partial;
    logic [31:0] ld_data;
    logic        drain_valid, drain_ready;
    logic [31:0] drain_addr, drain_data;
    logic [3:0]  drain_be;
    logic [2:0]  count;
    logic        full, empty;

    always #5 clk = ~clk;

    coalescing_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
        .ld_resp_valid(ld_resp_valid), .ld_hit(ld_hit), .ld_partial(ld_partial), .ld_data(ld_data),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
        .drain_data(drain_data), .drain_be(drain_be),
        .count(count), .full(full), .empty(empty)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] be2m(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    typedef struct {
        logic fl; logic sv; logic [31:0] sa; logic [31:0] sd; logic [3:0] sbe;
        logic dr; logic lv; logic [31:0] la; logic [3:0] lbe;
        logic e_rdy; int e_cnt; logic e_dv; logic [31:0] e_da; logic [31:0] e_dd; logic [3:0] e_dbe;
        logic e_lh; logic e_lp; logic [31:0] e_ld;
    } vec_t;

    function automatic vec_t v(input logic fl, sv, input logic [31:0] sa, sd, input logic [3:0] sbe,
                               input logic dr, lv, input logic [31:0] la, input logic [3:0] lbe,
                               input logic rdy, input int cnt, input logic dv, input logic [31:0] da, dd,
                               input logic [3:0] dbe, input logic lh, lp, input logic [31:0] ld);
        vec_t r;
        r = '{fl, sv, sa, sd, sbe, dr, lv, la, lbe, rdy, cnt, dv, da, dd, dbe, lh, lp, ld};
        return r;
    endfunction

    task automatic apply(input vec_t t, input int row);
        flush = t.fl; st_valid = t.sv; st_addr = t.sa; st_data = t.sd; st_be = t.sbe;
        drain_ready = t.dr; ld_valid = t.lv; ld_addr = t.la; ld_be = t.lbe;
        #1;
        chk($sformatf("row%0d st_ready", row), st_ready, t.e_rdy);
        chk($sformatf("row%0d count", row), count, t.e_cnt);
        chk($sformatf("row%0d full", row), full, t.e_cnt == DEPTH);
        chk($sformatf("row%0d empty", row), empty, t.e_cnt == 0);
        chk($sformatf("row%0d drain_valid", row), drain_valid, t.e_dv);
        if (t.e_dv) begin
            chk($sformatf("row%0d drain_addr", row), drain_addr, t.e_da);
            chk($sformatf("row%0d drain_data", row), drain_data, t.e_dd);
            chk($sformatf("row%0d drain_be", row), drain_be, t.e_dbe);
        end
        @(posedge clk); #1;
        chk($sformatf("row%0d ld_resp_valid", row), ld_resp_valid, t.lv);
        chk($sformatf("row%0d ld_hit", row), ld_hit, t.e_lh);
        chk($sformatf("row%0d ld_partial", row), ld_partial, t.e_lp);
        if (t.lv) chk($sformatf("row%0d ld_data", row), ld_data, t.e_ld);
    endtask

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] be; } ment_t;
    ment_t mq[$];
    vec_t  tv[$];

    initial begin
        reset = 1'b0; flush = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        drain_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_be = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", count, 0);
        chk("reset empty", empty, 1);
        chk("reset full", full, 0);
        chk("reset drain_valid", drain_valid, 0);
        chk("reset ld_resp_valid", ld_resp_valid, 0);
        chk("reset ld_hit", ld_hit, 0);
        chk("reset ld_partial", ld_partial, 0);
        chk("reset ld_data", ld_data, 0);
        reset = 1'b1;

        // fill, blocked store, drain in order
        tv.push_back(v(0,1,32'h10,32'h11111111,4'hF, 0,0,0,0, 1,0,0,0,0,0, 0,0,0));
        tv.push_back(v(0,1,32'h11,32'h22222222,4'hF, 0,0,0,0, 1,1,1,32'h10,32'h11111111,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h12,32'h33333333,4'hF, 0,0,0,0, 1,2,1,32'h10,32'h11111111,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h13,32'h44444444,4'hF, 0,0,0,0, 1,3,1,32'h10,32'h11111111,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h14,32'h55555555,4'hF, 0,0,0,0, 0,4,1,32'h10,32'h11111111,4'hF, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 1,0,0,0, 0,4,1,32'h10,32'h11111111,4'hF, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 1,0,0,0, 1,3,1,32'h11,32'h22222222,4'hF, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 1,0,0,0, 1,2,1,32'h12,32'h33333333,4'hF, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 1,0,0,0, 1,1,1,32'h13,32'h44444444,4'hF, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0));
        // coalesce and forwarding
        tv.push_back(v(0,1,32'h20,32'h000000AA,4'h1, 0,0,0,0, 1,0,0,0,0,0, 0,0,0));
        tv.push_back(v(0,1,32'h20,32'h0000BB00,4'h2, 0,0,0,0, 1,1,1,32'h20,32'h000000AA,4'h1, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 0,1,32'h20,4'h1, 1,1,1,32'h20,32'h0000BBAA,4'h3, 1,0,32'h0000BBAA));
        tv.push_back(v(0,0,0,0,0, 0,1,32'h20,4'hF, 1,1,1,32'h20,32'h0000BBAA,4'h3, 0,1,32'h0000BBAA));
        tv.push_back(v(0,0,0,0,0, 0,1,32'h30,4'hF, 1,1,1,32'h20,32'h0000BBAA,4'h3, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 1,0,0,0, 1,1,1,32'h20,32'h0000BBAA,4'h3, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0));
        // pop with same-cycle store to head (refused) and to a younger entry (coalesced)
        tv.push_back(v(0,1,32'h40,32'h40,4'hF, 0,0,0,0, 1,0,0,0,0,0, 0,0,0));
        tv.push_back(v(0,1,32'h41,32'h41,4'hF, 0,0,0,0, 1,1,1,32'h40,32'h40,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h42,32'h42,4'hF, 0,0,0,0, 1,2,1,32'h40,32'h40,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h43,32'h43,4'hF, 0,0,0,0, 1,3,1,32'h40,32'h40,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h40,32'hFF,4'hF, 1,0,0,0, 0,4,1,32'h40,32'h40,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h44,32'h44,4'hF, 0,0,0,0, 1,3,1,32'h41,32'h41,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h43,32'h0000FF00,4'h2, 1,0,0,0, 1,4,1,32'h41,32'h41,4'hF, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 1,1,32'h43,4'hF, 1,3,1,32'h42,32'h42,4'hF, 1,0,32'h0000FF43));
        tv.push_back(v(0,0,0,0,0, 1,0,0,0, 1,2,1,32'h43,32'h0000FF43,4'hF, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 1,0,0,0, 1,1,1,32'h44,32'h44,4'hF, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0));
        // flush with drain_ready high, store and load in the same cycle
        tv.push_back(v(0,1,32'h50,32'h50,4'hF, 0,0,0,0, 1,0,0,0,0,0, 0,0,0));
        tv.push_back(v(0,1,32'h51,32'h51,4'hF, 0,0,0,0, 1,1,1,32'h50,32'h50,4'hF, 0,0,0));
        tv.push_back(v(0,1,32'h52,32'h52,4'hF, 0,0,0,0, 1,2,1,32'h50,32'h50,4'hF, 0,0,0));
        tv.push_back(v(1,1,32'h53,32'h53,4'hF, 1,1,32'h50,4'hF, 0,3,0,0,0,0, 0,0,0));
        tv.push_back(v(0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0, 0,0,0));
        for (int r = 0; r < tv.size(); r++) apply(tv[r], r);

        // wrap-around: head/tail cross index DEPTH-1 several times
        for (int i = 0; i < 10; i++) begin
            logic [31:0] d;
            d = $urandom;
            flush = 0; st_valid = 1; st_addr = 32'h60 + i; st_data = d; st_be = 4'hF;
            drain_ready = 0; ld_valid = 0;
            #1;
            chk($sformatf("wrap%0d st_ready", i), st_ready, 1);
            chk($sformatf("wrap%0d count0", i), count, 0);
            @(posedge clk); #1;
            st_valid = 0; drain_ready = 1;
            #1;
            chk($sformatf("wrap%0d drain_valid", i), drain_valid, 1);
            chk($sformatf("wrap%0d drain_addr", i), drain_addr, 32'h60 + i);
            chk($sformatf("wrap%0d drain_data", i), drain_data, d);
            chk($sformatf("wrap%0d count1", i), count, 1);
            @(posedge clk); #1;
            drain_ready = 0;
        end

        // reset asserted while a store and a load are presented
        for (int i = 0; i < 2; i++) begin
            st_valid = 1; st_addr = 32'h70 + i; st_data = 32'hABCD0000 + i; st_be = 4'hF;
            @(posedge clk); #1;
        end
        reset = 0; st_valid = 1; st_addr = 32'h72; ld_valid = 1; ld_addr = 32'h70; ld_be = 4'hF;
        @(posedge clk); #1;
        chk("rst_mid count", count, 0);
        chk("rst_mid empty", empty, 1);
        chk("rst_mid full", full, 0);
        chk("rst_mid drain_valid", drain_valid, 0);
        chk("rst_mid ld_resp_valid", ld_resp_valid, 0);
        chk("rst_mid ld_hit", ld_hit, 0);
        chk("rst_mid ld_data", ld_data, 0);
        reset = 1; st_valid = 0; ld_valid = 0;
        #1;
        chk("rst_release count", count, 0);

        // randomized traffic against a queue model
        for (int c = 0; c < 3000; c++) begin
            int n, mi, li, idx;
            logic pop, usable, rdy, look, cov;
            logic e_lh, e_lp;
            logic [31:0] e_ld;
            logic e_lv;
            ment_t e;
            flush = ($urandom_range(0, 31) == 0);
            st_valid = $urandom_range(0, 1);
            st_addr = $urandom_range(0, 5);
            st_data = $urandom;
            st_be = 4'($urandom_range(1, 15));
            drain_ready = $urandom_range(0, 1);
            ld_valid = $urandom_range(0, 1);
            ld_addr = $urandom_range(0, 6);
            ld_be = 4'($urandom_range(1, 15));
            #1;
            n = mq.size();
            pop = (n != 0) && !flush && drain_ready;
            mi = -1;
            li = -1;
            for (int k = 0; k < n; k++) begin
                if (mq[k].addr == st_addr) mi = k;
                if (mq[k].addr == ld_addr) li = k;
            end
            usable = (mi >= 0) && !(mi == 0 && pop);
            rdy = !flush && (n < DEPTH || usable);
            chk($sformatf("rnd%0d st_ready", c), st_ready, rdy);
            chk($sformatf("rnd%0d count", c), count, n);
            chk($sformatf("rnd%0d full", c), full, n == DEPTH);
            chk($sformatf("rnd%0d empty", c), empty, n == 0);
            chk($sformatf("rnd%0d drain_valid", c), drain_valid, (n != 0) && !flush);
            if (n != 0 && !flush) begin
                chk($sformatf("rnd%0d drain_addr", c), drain_addr, mq[0].addr);
                chk($sformatf("rnd%0d drain_be", c), drain_be, mq[0].be);
                chk($sformatf("rnd%0d drain_data", c), drain_data & be2m(mq[0].be), mq[0].data);
            end
            look = ld_valid && !flush && (li >= 0);
            cov = (li >= 0) ? ((mq[li].be & ld_be) == ld_be) : 1'b0;
            e_lv = ld_valid;
            e_lh = look && cov;
            e_lp = look && !cov;
            e_ld = look ? mq[li].data : 32'h0;
            @(posedge clk); #1;
            chk($sformatf("rnd%0d ld_resp_valid", c), ld_resp_valid, e_lv);
            chk($sformatf("rnd%0d ld_hit", c), ld_hit, e_lh);
            chk($sformatf("rnd%0d ld_partial", c), ld_partial, e_lp);
            if (e_lv) chk($sformatf("rnd%0d ld_data", c), ld_data, e_ld);
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (st_valid && rdy) begin
                    if (usable) begin
                        idx = pop ? mi - 1 : mi;
                        e = mq[idx];
                        for (int b = 0; b < 4; b++) if (st_be[b]) e.data[8*b +: 8] = st_data[8*b +: 8];
                        e.be = e.be | st_be;
                        mq[idx] = e;
                    end else begin
                        e.addr = st_addr;
                        e.data = st_data & be2m(st_be);
                        e.be = st_be;
                        mq.push_back(e);
                    end
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
